cluster_input_assembler: RTL and testbench

// - Upstream stage of the cluster_1 output-bit evaluators. Collects the 1894-bit CPU state vector

---
 rtl/cluster_pkg.sv | 20 ++
 rtl/cluster_beat_writer.sv | 38 +++
 rtl/cluster_input_assembler.sv | 118 +++++++++++
 tb/tb_cluster_input_assembler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - sizes and FSM state type shared by the cluster input assembler
// Beat count and final-beat width are derived from VEC_W/BEAT_W and must stay derived.
package cluster_pkg;

  localparam int VEC_W     = 1894;
  localparam int BEAT_W    = 64;
  localparam int NUM_BEATS = (VEC_W + BEAT_W - 1) / BEAT_W;
  localparam int LAST_W    = VEC_W - (NUM_BEATS - 1) * BEAT_W;
  localparam int IDX_W     = $clog2(NUM_BEATS);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_t;

  function automatic logic is_final_beat(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NUM_BEATS - 1);
  endfunction

endpackage

// File: rtl/cluster_beat_writer.sv
// rtl/cluster_beat_writer.sv - beat index decode and per-beat write into the state vector register
// The final beat only carries LAST_W meaningful bits; its upper bits are discarded.
module cluster_beat_writer
  import cluster_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [VEC_W-1:0]  vec
);

  logic [NUM_BEATS-1:0] beat_we;

  always_comb begin
    beat_we = '0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      beat_we[k] = wr_en && (beat_idx == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else begin
      for (int k = 0; k < NUM_BEATS - 1; k++) begin
        if (beat_we[k]) begin
          vec[k*BEAT_W +: BEAT_W] <= beat_data;
        end
      end
      if (beat_we[NUM_BEATS-1]) begin
        vec[VEC_W-1 -: LAST_W] <= beat_data[LAST_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cluster_input_assembler.sv
// rtl/cluster_input_assembler.sv - assembles the CPU state vector from beats and holds it for the evaluators
// Optional beat parity checking is enabled with CLUSTER_ASM_PARITY_EN.
module cluster_input_assembler
  import cluster_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_last,
`ifdef CLUSTER_ASM_PARITY_EN
  input  logic              s_par,
`endif
  output logic [VEC_W-1:0]  vec_o,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic              err_o,
  output logic [7:0]        err_cnt,
  output logic [15:0]       frame_cnt
);

  asm_state_t       state;
  asm_state_t       state_nxt;
  logic [IDX_W-1:0] beat_idx;
  logic             accept;
  logic             final_beat;
  logic             terminate;
  logic             frame_bad;
  logic             frame_good;
  logic             frame_drop;

  assign accept     = s_valid & s_ready;
  assign final_beat = is_final_beat(beat_idx);
  assign terminate  = accept & (s_last | final_beat);
  assign frame_good = terminate & final_beat & s_last & ~frame_bad;
  assign frame_drop = terminate & ~frame_good;

`ifdef CLUSTER_ASM_PARITY_EN
  // Sticky per-frame flag; the current beat is folded in so a bad final beat also drops.
  logic par_bad;

  assign frame_bad = par_bad | (^{s_data, s_par});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
    end else if (terminate) begin
      par_bad <= 1'b0;
    end else if (accept) begin
      par_bad <= frame_bad;
    end
  end
`else
  assign frame_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    vec_valid = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (frame_good) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        vec_valid = 1'b1;
        if (vec_ready) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx  <= '0;
      err_o     <= 1'b0;
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      err_o <= frame_drop;
      if (terminate) begin
        beat_idx <= '0;
      end else if (accept) begin
        beat_idx <= beat_idx + IDX_W'(1);
      end
      if (frame_drop && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if ((state == HOLD) && vec_ready) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  cluster_beat_writer u_beat_writer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (accept),
    .beat_idx  (beat_idx),
    .beat_data (s_data),
    .vec       (vec_o)
  );

endmodule

// File: tb/tb_cluster_input_assembler.sv
// tb/tb_cluster_input_assembler.sv - self-checking bench for cluster_input_assembler
// Parity scenarios are exercised when CLUSTER_ASM_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_cluster_input_assembler;
  import cluster_pkg::*;

`ifdef CLUSTER_ASM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  logic s_par = 1'b0;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic [VEC_W-1:0]  vec_o;
  logic              vec_valid;
  logic              vec_ready = 1'b0;
  logic              err_o;
  logic [7:0]        err_cnt;
  logic [15:0]       frame_cnt;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int m_pulses = 0;
  int m_err = 0;
  int m_frames = 0;
  logic [VEC_W-1:0]  m_vec;
  logic [BEAT_W-1:0] beats [NUM_BEATS];

  typedef struct {
    int nbeats;
    int last_at;
    bit exp_ok;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  cluster_input_assembler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
`ifdef CLUSTER_ASM_PARITY_EN
    .s_par     (s_par),
`endif
    .vec_o     (vec_o),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .err_o     (err_o),
    .err_cnt   (err_cnt),
    .frame_cnt (frame_cnt)
  );

  always @(negedge clk) if (rst_n && err_o) err_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(string name, logic [VEC_W-1:0] exp);
    int first;
    first = 0;
    total++;
    if (vec_o !== exp) begin
      bad++;
      for (int b = VEC_W - 1; b >= 0; b--) if (vec_o[b] !== exp[b]) first = b;
      $display("FAIL %s: vec_o bit %0d got %b expected %b", name, first, vec_o[first], exp[first]);
    end
  endtask

  task automatic build_model();
    m_vec = '0;
    for (int k = 0; k < NUM_BEATS; k++)
      for (int b = 0; b < BEAT_W; b++)
        if (k * BEAT_W + b < VEC_W) m_vec[k * BEAT_W + b] = beats[k][b];
  endtask

  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && t < 100) begin
      step();
      t++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Model: a frame is delivered only if it has exactly NUM_BEATS beats, s_last on the last, clean parity.
  task automatic send_frame(input int nbeats, input int last_at, input int bad_par_at,
                            input bit ones, output bit ok);
    logic [BEAT_W-1:0] d;
    logic p;
    bit par_ok;
    par_ok = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      d = {$urandom, $urandom};
      if (ones && k == NUM_BEATS - 1) d = '1;
      p = (^d) ^ (k == bad_par_at);
      if (^{d, p}) par_ok = 1'b0;
      beats[k] = d;
`ifdef CLUSTER_ASM_PARITY_EN
      s_par = p;
`endif
      send_beat(d, k == last_at);
    end
    ok = (nbeats == NUM_BEATS) && (last_at == NUM_BEATS - 1) && (!PAR_EN || par_ok);
    if (ok) begin
      build_model();
      m_frames++;
    end else begin
      m_pulses++;
      if (m_err < 255) m_err++;
    end
  endtask

  task automatic check_frame(string name, bit ok, int stall);
    bit stable;
    bit rdy_low;
    if (ok) begin
      chk({name, "_vec_valid"}, vec_valid, 1);
      chk_vec({name, "_vec"}, m_vec);
      stable = 1'b1;
      rdy_low = 1'b1;
      for (int c = 0; c < stall; c++) begin
        s_valid = 1'b1;
        s_data  = {$urandom, $urandom};
        s_last  = 1'($urandom_range(0, 1));
        step();
        if (vec_o !== m_vec || vec_valid !== 1'b1) stable = 1'b0;
        if (s_ready !== 1'b0) rdy_low = 1'b0;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (stall > 0) begin
        chk({name, "_hold_stable"}, stable, 1);
        chk({name, "_hold_s_ready_low"}, rdy_low, 1);
      end
      vec_ready = 1'b1;
      step();
      vec_ready = 1'b0;
      chk({name, "_released"}, vec_valid, 0);
      chk({name, "_s_ready_back"}, s_ready, 1);
      chk({name, "_frame_cnt"}, frame_cnt, 64'(m_frames & 16'hFFFF));
    end else begin
      chk({name, "_no_vec_valid"}, vec_valid, 0);
      step();
      chk({name, "_err_cnt"}, err_cnt, 64'(m_err));
    end
    chk({name, "_err_pulses"}, err_seen, 64'(m_pulses));
  endtask

  task automatic reset_checks(string name);
    chk({name, "_vec_valid"}, vec_valid, 0);
    chk({name, "_s_ready"}, s_ready, 1);
    chk({name, "_err_o"}, err_o, 0);
    chk({name, "_err_cnt"}, err_cnt, 0);
    chk({name, "_frame_cnt"}, frame_cnt, 0);
    chk_vec({name, "_vec_o"}, '0);
  endtask

  initial begin
    bit ok;
    int nb, la, bp, kind;

    tbl[0] = '{NUM_BEATS, NUM_BEATS - 1, 1'b1};
    tbl[1] = '{11, 10, 1'b0};
    tbl[2] = '{NUM_BEATS, -1, 1'b0};
    tbl[3] = '{1, 0, 1'b0};
    tbl[4] = '{NUM_BEATS, NUM_BEATS - 1, 1'b1};
    tbl[5] = '{NUM_BEATS - 1, NUM_BEATS - 2, 1'b0};

    step();
    step();
    reset_checks("reset");
    rst_n = 1'b1;
    step();

    // First frame: vec_valid must stay low until the final beat is accepted.
    for (int k = 0; k < NUM_BEATS; k++) begin
      beats[k] = {$urandom, $urandom};
`ifdef CLUSTER_ASM_PARITY_EN
      s_par = ^beats[k];
`endif
      send_beat(beats[k], k == NUM_BEATS - 1);
      if (k == NUM_BEATS - 2) chk("first_valid_before_last", vec_valid, 0);
    end
    build_model();
    m_frames++;
    check_frame("first", 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].nbeats, tbl[i].last_at, -1, 1'b0, ok);
      check_frame($sformatf("tbl%0d", i), tbl[i].exp_ok, 0);
    end

    send_frame(NUM_BEATS, NUM_BEATS - 1, -1, 1'b1, ok);
    chk("ones_top_bits", vec_o[VEC_W-1 -: LAST_W], 64'({LAST_W{1'b1}}));
    check_frame("ones", ok, 0);

    send_frame(NUM_BEATS, NUM_BEATS - 1, -1, 1'b0, ok);
    check_frame("stall20", ok, 20);

    for (int i = 0; i < 25; i++) begin
      kind = $urandom_range(0, 3);
      nb = NUM_BEATS;
      la = NUM_BEATS - 1;
      if (kind == 2) begin
        la = $urandom_range(0, NUM_BEATS - 2);
        nb = la + 1;
      end else if (kind == 3) begin
        la = -1;
      end
      bp = (PAR_EN && $urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      send_frame(nb, la, bp, 1'b0, ok);
      check_frame("rand", ok, $urandom_range(0, 5));
    end

`ifdef CLUSTER_ASM_PARITY_EN
    // Bad parity on beat 5: the drop is reported only at the terminating beat.
    for (int k = 0; k < NUM_BEATS; k++) begin
      beats[k] = {$urandom, $urandom};
      s_par = (^beats[k]) ^ (k == 5);
      send_beat(beats[k], k == NUM_BEATS - 1);
      if (k == NUM_BEATS - 2) begin
        step();
        chk("par5_no_early_err", err_seen, 64'(m_pulses));
      end
    end
    m_pulses++;
    if (m_err < 255) m_err++;
    check_frame("par5", 1'b0, 0);
`endif

    // Reset in the middle of a frame discards it and clears everything.
    for (int k = 0; k < 15; k++) begin
      beats[k] = {$urandom, $urandom};
`ifdef CLUSTER_ASM_PARITY_EN
      s_par = ^beats[k];
`endif
      send_beat(beats[k], 1'b0);
    end
    rst_n = 1'b0;
    #2;
    reset_checks("midreset");
    step();
    rst_n = 1'b1;
    m_err = 0;
    m_frames = 0;
    step();
    send_frame(NUM_BEATS, NUM_BEATS - 1, -1, 1'b0, ok);
    check_frame("after_reset", ok, 0);

    // 300 dropped frames saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      send_frame(1, 0, -1, 1'b0, ok);
    end
    step();
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_err_pulses", err_seen, 64'(m_pulses));
    send_frame(NUM_BEATS, NUM_BEATS - 1, -1, 1'b0, ok);
    check_frame("post_sat", ok, 0);
    chk("post_sat_err_cnt", err_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
